// File: rtl/spi_pkg.sv
// Shared SPI target definitions: mode bit positions, FSM states and word helpers.
package spi_pkg;
    localparam int unsigned CPOL   = 1;
    localparam int unsigned CPHA   = 0;
    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    // Keeps the low ws+1 bits of a word.
    function automatic logic [WORD_W-1:0] word_mask(input logic [4:0] ws);
        return {WORD_W{1'b1}} >> (5'd31 - ws);
    endfunction
endpackage

// File: rtl/spi_target_sync.sv
// Pin synchronizer with registered rising/falling strobes; the level output is aligned
// with the strobes so data pins can be sampled in the same cycle as an edge strobe.
module spi_target_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_q    = r_prev;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversampled pins, MSB-first shift registers with back-to-back
// words per CS frame, rx/tx fabric handshakes and sticky overrun/underrun flags.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [4:0]        i_word_size,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_cs_n,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic [WORD_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    input  logic [WORD_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_overrun,
    output logic              o_underrun,
    input  logic              i_clear_flags,
    output logic              o_busy
);
    localparam int unsigned              FLUSH_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0]       FLUSH_CYC = FLUSH_W'(SYNC_STAGES + 1);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_unused;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_mosi),
        .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

    state_e              r_state, w_state_nxt;
    logic                r_cpol, w_cpol_nxt, r_cpha, w_cpha_nxt;
    logic [4:0]          r_wsize, w_wsize_nxt, r_ptr, w_ptr_nxt;
    logic [WORD_W-1:0]   r_shift_tx, w_shift_tx_nxt, r_shift_rx, w_shift_rx_nxt;
    logic [WORD_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic                r_miso, w_miso_nxt, r_rx_valid, w_rx_valid_nxt;
    logic                r_tx_ready, w_tx_ready_nxt;
    logic                r_overrun, w_overrun_nxt, r_underrun, w_underrun_nxt;
    logic [FLUSH_W-1:0]  r_flush_cnt;
    logic                r_armed;

    logic [WORD_W-1:0]   w_load, w_rx_word;
    logic                w_sample_edge, w_shift_edge;

    assign w_load        = i_tx_valid ? i_tx_data : '0;
    assign w_rx_word     = {r_shift_rx[WORD_W-2:0], w_mosi};
    // Sample on the rising edge exactly when CPOL == CPHA.
    assign w_sample_edge = (r_cpol == r_cpha) ? w_sclk_rise : w_sclk_fall;
    assign w_shift_edge  = (r_cpol == r_cpha) ? w_sclk_fall : w_sclk_rise;

    // After reset the synchronizer flushes fabricated history; a frame may only start once
    // CS has been seen deasserted, so a CS held low through reset cannot restart a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            if (r_flush_cnt != FLUSH_CYC) r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
            r_armed <= r_armed | ((r_flush_cnt == FLUSH_CYC) & w_cs_q);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cpol_nxt     = r_cpol;
        w_cpha_nxt     = r_cpha;
        w_wsize_nxt    = r_wsize;
        w_ptr_nxt      = r_ptr;
        w_shift_tx_nxt = r_shift_tx;
        w_shift_rx_nxt = r_shift_rx;
        w_miso_nxt     = r_miso;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = r_rx_valid & ~i_rx_ready;
        w_tx_ready_nxt = 1'b0;
        w_overrun_nxt  = r_overrun & ~i_clear_flags;
        w_underrun_nxt = r_underrun & ~i_clear_flags;
        unique case (r_state)
            StIdle: begin
                if (w_cs_fall && i_enable && r_armed) begin
                    w_state_nxt    = StActive;
                    w_cpol_nxt     = i_mode[CPOL];
                    w_cpha_nxt     = i_mode[CPHA];
                    w_wsize_nxt    = i_word_size;
                    w_ptr_nxt      = i_word_size;
                    w_shift_rx_nxt = '0;
                    w_shift_tx_nxt = w_load;
                    w_tx_ready_nxt = i_tx_valid;
                    if (!i_tx_valid) w_underrun_nxt = 1'b1;
                    if (!i_mode[CPHA]) w_miso_nxt = w_load[i_word_size];
                end
            end
            StActive: begin
                if (w_cs_rise || !i_enable) begin
                    w_state_nxt    = StIdle;
                    w_ptr_nxt      = '0;
                    w_shift_rx_nxt = '0;
                end else if (w_shift_edge) begin
                    w_miso_nxt = r_shift_tx[r_ptr];
                end else if (w_sample_edge) begin
                    w_shift_rx_nxt = w_rx_word;
                    if (r_ptr != 5'd0) begin
                        w_ptr_nxt = r_ptr - 5'd1;
                    end else begin
                        if (r_rx_valid && !i_rx_ready) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_rx_data_nxt  = w_rx_word & word_mask(r_wsize);
                            w_rx_valid_nxt = 1'b1;
                        end
                        w_shift_tx_nxt = w_load;
                        w_ptr_nxt      = r_wsize;
                        w_tx_ready_nxt = i_tx_valid;
                        if (!i_tx_valid) w_underrun_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_wsize    <= '0;
            r_ptr      <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cpol     <= w_cpol_nxt;
            r_cpha     <= w_cpha_nxt;
            r_wsize    <= w_wsize_nxt;
            r_ptr      <= w_ptr_nxt;
            r_shift_tx <= w_shift_tx_nxt;
            r_shift_rx <= w_shift_rx_nxt;
            r_miso     <= w_miso_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_overrun  <= w_overrun_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign o_miso     = r_miso;
    assign o_miso_oe  = r_armed & ~w_cs_q & i_enable;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_ready = r_tx_ready;
    assign o_overrun  = r_overrun;
    assign o_underrun = r_underrun;
    assign o_busy     = (r_state == StActive);
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-banged SPI host, a tx feeder, a frame-level reference model
// and an rx scoreboard monitor.
module tb_spi_target;
    localparam int HP = 6;  // SCLK half-period in clk cycles

    logic        clk = 1'b0;
    logic        reset, enable, sclk, mosi, cs_n, miso, miso_oe;
    logic [1:0]  mode;
    logic [4:0]  word_size;
    logic [31:0] rx_data, tx_data;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, overrun, underrun, clear_flags, busy;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mode(mode),
        .i_word_size(word_size), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n),
        .o_miso(miso), .o_miso_oe(miso_oe), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_overrun(overrun), .o_underrun(underrun),
        .i_clear_flags(clear_flags), .o_busy(busy)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          tx_pulses = 0;
    logic [31:0] exp_rx[$];
    logic [31:0] tx_feed[$];
    logic        exp_over = 1'b0, exp_under = 1'b0, rx_pend = 1'b0;
    logic [31:0] h_tx[4];
    logic [31:0] h_rx[4];
    logic [31:0] t_tx[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Fabric tx side: offers queued words, advances on each tx_ready pulse.
    always @(negedge clk) begin
        if (tx_ready === 1'b1) begin
            tx_pulses++;
            if (tx_feed.size() > 0) void'(tx_feed.pop_front());
        end
        tx_valid = (tx_feed.size() > 0);
        tx_data  = tx_valid ? tx_feed[0] : 32'd0;
    end

    // Rx scoreboard monitor.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got word 0x%08h, expected none", rx_data);
            end else begin
                check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic host_pins(input logic [1:0] m, input int ws, input int nbits, input bit chk_oe);
        int w, p;
        @(negedge clk);
        sclk = m[1];
        mosi = 1'b0;
        repeat (HP) @(negedge clk);
        cs_n = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            w = b / (ws + 1);
            p = ws - (b % (ws + 1));
            if (!m[0]) mosi = h_tx[w][p];
            repeat (HP) @(negedge clk);
            if (b == 0 && chk_oe) check("miso_oe", 32'(miso_oe), 32'd1);
            if (m[0]) mosi = h_tx[w][p];
            else h_rx[w][p] = miso;
            sclk = ~m[1];
            repeat (HP) @(negedge clk);
            if (m[0]) h_rx[w][p] = miso;
            sclk = m[1];
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HP) @(negedge clk);
    endtask

    // One CS frame: the model predicts loads, flags and words from whole-frame counts.
    task automatic run_frame(input logic [1:0] m, input int ws, input int nbits, input int ntx,
                             input logic rxr, input string tag);
        logic [31:0] mask;
        int done_w, loads, exp_pulses, p0;
        mask   = 32'((64'd1 << (ws + 1)) - 64'd1);
        done_w = nbits / (ws + 1);
        loads  = done_w + 1;
        @(negedge clk);
        mode      = m;
        word_size = 5'(ws);
        rx_ready  = rxr;
        for (int i = 0; i < ntx; i++) tx_feed.push_back(t_tx[i]);
        exp_pulses = (ntx < loads) ? ntx : loads;
        if (ntx < loads) exp_under = 1'b1;
        for (int i = 0; i < done_w; i++) begin
            if (!rxr && rx_pend) begin
                exp_over = 1'b1;
            end else begin
                exp_rx.push_back(h_tx[i] & mask);
                rx_pend = !rxr;
            end
        end
        p0 = tx_pulses;
        host_pins(m, ws, nbits, 1'b1);
        check({tag, "_tx_ready_pulses"}, 32'(tx_pulses - p0), 32'(exp_pulses));
        for (int i = 0; i < done_w; i++) begin
            check($sformatf("%s_miso_word%0d", tag, i), h_rx[i] & mask,
                  ((i < ntx) ? t_tx[i] : 32'd0) & mask);
        end
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_over));
        check({tag, "_underrun"}, 32'(underrun), 32'(exp_under));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_rx_data"}, rx_data, 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ws, nw, ntx;
        reset = 1'b1; enable = 1'b1; mode = 2'b00; word_size = 5'd7;
        sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rx_ready = 1'b1; clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_checks("rst");
        repeat (10) @(negedge clk);

        h_tx[0] = 32'hA5; t_tx[0] = 32'h3C;
        run_frame(2'b00, 7, 8, 1, 1'b1, "m0");
        check("m0_rx_data_hold", rx_data, 32'h0000_00A5);

        h_tx[0] = 32'h1234_5678; t_tx[0] = 32'hDEAD_BEEF;
        run_frame(2'b11, 31, 32, 1, 1'b1, "m3");
        check("m3_rx_data_hold", rx_data, 32'h1234_5678);

        pulse_clear();
        h_tx[0] = 32'h11; h_tx[1] = 32'h22; t_tx[0] = 32'hC3; t_tx[1] = 32'h96;
        run_frame(2'b00, 7, 16, 2, 1'b0, "ovr");
        check("ovr_rx_data_kept", rx_data, 32'h11);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_pend  = 1'b0;
        repeat (3) @(negedge clk);
        pulse_clear();
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_underrun", 32'(underrun), 32'd0);

        h_tx[0] = 32'h5C;
        run_frame(2'b00, 7, 8, 0, 1'b1, "udr");
        pulse_clear();

        h_tx[0] = 32'hFF; t_tx[0] = 32'h77;
        run_frame(2'b01, 7, 5, 1, 1'b1, "abort");
        h_tx[0] = 32'h5A; t_tx[0] = 32'hA1;
        run_frame(2'b01, 7, 8, 1, 1'b1, "m1");
        check("m1_rx_data_hold", rx_data, 32'h5A);

        // Reset mid-word with CS still low; the tail of this frame must be ignored.
        @(negedge clk);
        mode = 2'b00; word_size = 5'd7; h_tx[0] = 32'hC6;
        fork
            host_pins(2'b00, 7, 8, 1'b0);
            begin
                repeat (HP * 8) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                exp_over = 1'b0; exp_under = 1'b0; rx_pend = 1'b0;
                reset_checks("midrst");
            end
        join
        check("midrst_busy_after", 32'(busy), 32'd0);

        h_tx[0] = 32'hBEEF; t_tx[0] = 32'h1357; t_tx[1] = 32'h2468;
        run_frame(2'b10, 15, 16, 2, 1'b1, "post");

        for (int it = 0; it < 10; it++) begin
            ws  = $urandom_range(31, 3);
            nw  = $urandom_range(2, 1);
            ntx = $urandom_range(nw + 1, 0);
            for (int i = 0; i < 4; i++) begin
                h_tx[i] = $urandom;
                t_tx[i] = $urandom;
            end
            run_frame(2'($urandom_range(3, 0)), ws, nw * (ws + 1), ntx, 1'b1,
                      $sformatf("rnd%0d", it));
        end

        repeat (5) @(negedge clk);
        check("rx_drain", 32'(exp_rx.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) endpoint that sits directly downstream of the SPI host controller's pin interface: it consumes `sclk`, `tx` (MOSI) and one active-low chip select, shifts received words into a holding register for the local fabric, and drives the host's `rx` line (MISO) from a transmit word supplied by the fabric. It is the loopback and bring-up partner for the host controller on the DE1-SoC. It also serves as the target core for FPGA-side peripherals. All SPI pins are oversampled in the system clock domain; no logic runs on `sclk`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `sclk`, `mosi`, `cs_n`.
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: synchronous, active-high; sampled on `clk` rising edge.
- `enable`  in  1: target enable; when low, the FSM is held in IDLE and `miso_oe` is 0.
- `mode`  in  2: `{CPOL, CPHA}`, same encoding as the host's per-CS MODE field.
- `word_size`  in  5: bits per word minus 1 (31 means 32 bits); MSB first.
- `sclk`, `mosi`, `cs_n`  in  1 each: SPI pins from the host (`sclk`, `tx`, `csN`).
- `miso`  out  1: serial data to the host `rx` pin.
- `miso_oe`  out  1: output enable, high while `cs_n` is low (synchronized) and `enable` is high.
- `rx_data`  out  32: last completed received word, right-aligned, upper bits zero.
- `rx_valid`  out  1 / `rx_ready`  in  1: receive handshake; the word is consumed on a cycle where both are high.
- `tx_data`  in  32 / `tx_valid`  in  1: next word to send.
- `tx_ready`  out  1: one-cycle pulse when `tx_data` is taken.
- `overrun`, `underrun`  out  1 each: sticky error flags.
- `clear_flags`  in  1: clears both sticky error flags.
- `busy`  out  1: high in ACTIVE.

## Operation
- Synchronized pins feed a registered previous value. `sclk_rise`/`sclk_fall`/`cs_fall`/`cs_rise` are one-cycle strobes.
- Leading edge is the transition away from CPOL. Trailing edge is the return to CPOL.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- FSM states:
  - IDLE to ACTIVE on `cs_fall` with `enable` high. On that transition:
    - Load the word: `shift_tx <= tx_valid ? tx_data : 0`, pulse `tx_ready` if `tx_valid`, otherwise set `underrun`.
    - `ptr <= word_size`, `shift_rx <= 0`.
    - If CPHA=0, also `miso <= loaded word[word_size]`.
  - ACTIVE, shift edge: `miso <= shift_tx[ptr]`.
  - ACTIVE, sample edge: `shift_rx <= {shift_rx[30:0], mosi}`.
    - If `ptr != 0`: `ptr <= ptr - 1`.
    - If `ptr == 0`, the word is complete:
      - If `rx_valid` is high and `rx_ready` is low, set `overrun` and keep the old `rx_data`. Otherwise `rx_data <= {shift_rx[30:0], mosi}` masked to `word_size+1` bits, and `rx_valid <= 1`.
      - Then reload `shift_tx`/`ptr`/`tx_ready`/`underrun` exactly as on the IDLE to ACTIVE transition, without touching `miso`. The next word runs back-to-back in the same CS frame.
  - ACTIVE to IDLE on `cs_rise` or `enable` low. The partial word is discarded, no `rx_valid`, and `ptr`/`shift_rx` are cleared.
- `rx_valid` clears on a cycle where `rx_valid & rx_ready` is high. A new word completing in that same cycle wins: `rx_valid` stays 1 with the new data.
- `clear_flags` with a simultaneous new error: the error wins (flag stays set).
- `mode` and `word_size` are sampled only at IDLE to ACTIVE; changes mid-frame have no effect until the next frame.
- Edge strobes in IDLE are ignored. `sclk` and `cs_fall` arriving in the same cycle: the CS transition is processed first and the `sclk` edge is dropped.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=0, `overrun`=0, `underrun`=0, `busy`=0; FSM in IDLE; synchronizers cleared to `sclk`=CPOL-agnostic 0 and `cs_n`=1.
- Reset mid-frame aborts immediately. The first post-reset frame begins only on a fresh `cs_fall`.
- Pin-to-strobe latency is `SYNC_STAGES`+1 `clk` cycles.
- `miso` updates 1 cycle after a shift strobe. `rx_valid` rises 1 cycle after the final sample strobe.
- SCLK half-period must be at least `SYNC_STAGES`+2 `clk` cycles. The host default of 5 MHz at 50 MHz (5 cycles) meets this.
- Setup rule: the host must wait at least one half-period after CS assert before the first edge.

## Structure
- Shared package `spi_pkg`: mode bit indices (`CPOL`=1, `CPHA`=0), FSM state enum (IDLE, ACTIVE), word width constant 32.
- One sub-module, `spi_target_sync`: parameterized synchronizer plus rising/falling edge detector, instantiated three times.
- The FSM, shift registers and flag logic live in `spi_target`.

## Test plan
- Mode 0, `word_size`=7, `tx_data`=0x3C, host sends 0xA5: `rx_data`=0x000000A5 with one `rx_valid`; host receives 0x3C; exactly one `tx_ready` pulse.
- Mode 3, `word_size`=31, `tx_data`=0xDEADBEEF, host sends 0x12345678: `rx_data`=0x12345678; MISO yields 0xDEADBEEF MSB first.
- Two 8-bit words (0x11, 0x22) in one CS frame, `rx_ready` held low: first word is kept, `overrun`=1, host reads the second tx word correctly; `clear_flags` then clears `overrun` to 0.
- `tx_valid`=0 at CS assert: `underrun`=1, host receives 0x00, no `tx_ready` pulse.
- CS deasserted after 5 of 8 bits in mode 1: no `rx_valid`, `busy` falls to 0; the next full frame with 0x5A yields `rx_data`=0x5A.
- `reset` asserted mid-word for 1 cycle: all outputs return to reset values; the following frame behaves normally.
